// File: rtl/ofs_fim_pcie_pkg.sv
// ofs_fim_pcie_pkg: FLR function record and sequencer state shared with the PCIe subsystem BFM.
package ofs_fim_pcie_pkg;
  localparam int FLR_PF_W = 3;
  localparam int FLR_VF_W = 11;
  typedef struct packed {
    logic [FLR_PF_W-1:0] pf;
    logic [FLR_VF_W-1:0] vf;
    logic                vf_active;
  } t_flr_func;
  typedef enum logic [1:0] {FLR_IDLE, FLR_ASSERT, FLR_DRAIN, FLR_RESP} t_flr_state;
endpackage

// File: rtl/host_flr_sequencer_if.sv
// host_flr_sequencer_if: FLR request/response, function-reset and status signals of the sequencer.
interface host_flr_sequencer_if #(
  parameter int PF_WIDTH   = 3,
  parameter int VF_WIDTH   = 11,
  parameter int FIFO_DEPTH = 8
);
  logic                        flr_req_valid;
  logic [PF_WIDTH-1:0]         flr_req_pf;
  logic [VF_WIDTH-1:0]         flr_req_vf;
  logic                        flr_req_vf_active;
  logic                        port_idle;
  logic                        func_rst_valid;
  logic [PF_WIDTH-1:0]         func_rst_pf;
  logic [VF_WIDTH-1:0]         func_rst_vf;
  logic                        func_rst_vf_active;
  logic                        flr_rsp_valid;
  logic [PF_WIDTH-1:0]         flr_rsp_pf;
  logic [VF_WIDTH-1:0]         flr_rsp_vf;
  logic                        flr_rsp_vf_active;
  logic                        busy;
  logic [$clog2(FIFO_DEPTH):0] pending_cnt;
  logic                        overflow_err;
  logic                        timeout_err;
  modport master (
    output flr_req_valid, flr_req_pf, flr_req_vf, flr_req_vf_active, port_idle,
    input  func_rst_valid, func_rst_pf, func_rst_vf, func_rst_vf_active,
    input  flr_rsp_valid, flr_rsp_pf, flr_rsp_vf, flr_rsp_vf_active,
    input  busy, pending_cnt, overflow_err, timeout_err
  );
  modport slave (
    input  flr_req_valid, flr_req_pf, flr_req_vf, flr_req_vf_active, port_idle,
    output func_rst_valid, func_rst_pf, func_rst_vf, func_rst_vf_active,
    output flr_rsp_valid, flr_rsp_pf, flr_rsp_vf, flr_rsp_vf_active,
    output busy, pending_cnt, overflow_err, timeout_err
  );
endinterface

// File: rtl/host_flr_req_fifo.sv
// host_flr_req_fifo: synchronous FIFO with full/empty/count; a write into a full FIFO is dropped unless a pop frees a slot the same cycle.
module host_flr_req_fifo #(
  parameter int W     = 15,
  parameter int DEPTH = 8
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     i_wr,
  input  logic [W-1:0]             i_data,
  input  logic                     i_rd,
  output logic [W-1:0]             o_data,
  output logic                     o_full,
  output logic                     o_empty,
  output logic [$clog2(DEPTH):0]   o_count
);
  localparam int AW = $clog2(DEPTH);
  logic [W-1:0]  r_mem [DEPTH];
  logic [AW-1:0] r_wp, r_rp;
  logic [AW:0]   r_cnt;
  logic          w_rd, w_wr;
  assign o_empty = r_cnt == '0;
  assign o_full  = r_cnt == (AW+1)'(DEPTH);
  assign o_count = r_cnt;
  assign o_data  = r_mem[r_rp];
  assign w_rd    = i_rd && !o_empty;
  assign w_wr    = i_wr && (!o_full || w_rd);
  always_ff @(posedge clk) begin
    if (rst) begin
      r_wp  <= '0;
      r_rp  <= '0;
      r_cnt <= '0;
    end else begin
      if (w_wr) r_mem[r_wp] <= i_data;
      if (w_wr) r_wp <= r_wp + AW'(1);
      if (w_rd) r_rp <= r_rp + AW'(1);
      r_cnt <= r_cnt + (AW+1)'(w_wr) - (AW+1)'(w_rd);
    end
  end
endmodule

// File: rtl/host_flr_sequencer.sv
// host_flr_sequencer: queues FLR requests, pulses the function reset, waits for drain, returns the FLR response.
// Optional drain timeout enabled by defining HOST_FLR_DRAIN_TIMEOUT_EN.
module host_flr_sequencer
  import ofs_fim_pcie_pkg::*;
#(
  parameter int PF_WIDTH      = FLR_PF_W,
  parameter int VF_WIDTH      = FLR_VF_W,
  parameter int FIFO_DEPTH    = 8,
  parameter int RST_CYCLES    = 16,
  parameter int DRAIN_TIMEOUT = 4096
) (
  input logic                 clk,
  input logic                 reset,
  host_flr_sequencer_if.slave bus
);
  localparam int FW   = PF_WIDTH + VF_WIDTH + 1;
  localparam int MAXC = RST_CYCLES > DRAIN_TIMEOUT ? RST_CYCLES : DRAIN_TIMEOUT;
  localparam int CW   = $clog2(MAXC + 1);
  t_flr_state    r_state, w_next;
  logic [FW-1:0] r_func, w_head, w_out;
  logic [CW-1:0] r_cnt;
  logic          r_ovf, w_full, w_empty, w_pop, w_act;
  host_flr_req_fifo #(.W(FW), .DEPTH(FIFO_DEPTH)) u_fifo (
    .clk     (clk),
    .rst     (reset),
    .i_wr    (bus.flr_req_valid),
    .i_data  ({bus.flr_req_pf, bus.flr_req_vf, bus.flr_req_vf_active}),
    .i_rd    (w_pop),
    .o_data  (w_head),
    .o_full  (w_full),
    .o_empty (w_empty),
    .o_count (bus.pending_cnt)
  );
  assign w_pop = r_state == FLR_IDLE && !w_empty;
`ifdef HOST_FLR_DRAIN_TIMEOUT_EN
  logic r_tmo, w_tmo;
  assign w_tmo = r_state == FLR_DRAIN && !bus.port_idle && r_cnt == CW'(DRAIN_TIMEOUT - 1);
  always_ff @(posedge clk) begin
    if (reset) r_tmo <= 1'b0;
    else       r_tmo <= r_tmo | w_tmo;
  end
  assign bus.timeout_err = r_tmo;
`else
  logic w_tmo;
  assign w_tmo = 1'b0;
  assign bus.timeout_err = 1'b0;
`endif
  always_comb begin
    w_next = r_state;
    case (r_state)
      FLR_IDLE:   w_next = w_empty ? FLR_IDLE : FLR_ASSERT;
      FLR_ASSERT: w_next = r_cnt == CW'(RST_CYCLES - 1) ? FLR_DRAIN : FLR_ASSERT;
      FLR_DRAIN:  w_next = (bus.port_idle || w_tmo) ? FLR_RESP : FLR_DRAIN;
      default:    w_next = FLR_IDLE;
    endcase
  end
  // The cycle counter restarts on every state change, so ASSERT and DRAIN each count from their first cycle.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= FLR_IDLE;
      r_func  <= '0;
      r_cnt   <= '0;
      r_ovf   <= 1'b0;
    end else begin
      r_state <= w_next;
      if (w_pop) r_func <= w_head;
      r_cnt   <= w_next != r_state ? '0 : r_cnt + CW'(1);
      r_ovf   <= r_ovf | (bus.flr_req_valid & w_full & ~w_pop);
    end
  end
  assign w_act = r_state != FLR_IDLE;
  assign w_out = w_act ? r_func : '0;
  assign {bus.func_rst_pf, bus.func_rst_vf, bus.func_rst_vf_active} = w_out;
  assign {bus.flr_rsp_pf, bus.flr_rsp_vf, bus.flr_rsp_vf_active}    = w_out;
  assign bus.func_rst_valid = r_state == FLR_ASSERT;
  assign bus.flr_rsp_valid  = r_state == FLR_RESP;
  assign bus.busy           = w_act || !w_empty;
  assign bus.overflow_err   = r_ovf;
endmodule

// File: tb/tb_host_flr_sequencer.sv
// tb_host_flr_sequencer: directed vector table plus hand-written multi-cycle sequences for host_flr_sequencer.
module tb_host_flr_sequencer;
  import ofs_fim_pcie_pkg::*;
  logic clk = 1'b0;
  logic reset;
  int   n_cmp = 0;
  int   n_err = 0;
  always #5 clk = ~clk;
  host_flr_sequencer_if #(.PF_WIDTH(3), .VF_WIDTH(11), .FIFO_DEPTH(8)) bus ();
  host_flr_sequencer #(
    .PF_WIDTH(3), .VF_WIDTH(11), .FIFO_DEPTH(8), .RST_CYCLES(16), .DRAIN_TIMEOUT(64)
  ) dut (.clk(clk), .reset(reset), .bus(bus));

  typedef struct {
    t_flr_func req;
    t_flr_func exp;
  } vec_t;
  vec_t vecs [4];

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  function automatic logic [63:0] all_out();
    return {bus.func_rst_valid, bus.func_rst_pf, bus.func_rst_vf, bus.func_rst_vf_active,
            bus.flr_rsp_valid, bus.flr_rsp_pf, bus.flr_rsp_vf, bus.flr_rsp_vf_active,
            bus.busy, bus.pending_cnt, bus.overflow_err, bus.timeout_err};
  endfunction

  task automatic push(input logic [2:0] pf, input logic [10:0] vf, input logic vfa);
    bus.flr_req_valid     = 1'b1;
    bus.flr_req_pf        = pf;
    bus.flr_req_vf        = vf;
    bus.flr_req_vf_active = vfa;
    step();
    bus.flr_req_valid     = 1'b0;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    step();
    step();
    reset = 1'b0;
  endtask

  initial begin
    int first;
    int nrsp;
    logic [10:0] got_vf [$];
    logic [2:0]  got_pf [$];
    bus.flr_req_valid = 1'b0;
    bus.flr_req_pf = '0;
    bus.flr_req_vf = '0;
    bus.flr_req_vf_active = 1'b0;
    bus.port_idle = 1'b1;
    vecs[0] = '{req: '{3'd2, 11'd0,     1'b0}, exp: '{3'd2, 11'd0,     1'b0}};
    vecs[1] = '{req: '{3'd7, 11'h7ff,   1'b1}, exp: '{3'd7, 11'h7ff,   1'b1}};
    vecs[2] = '{req: '{3'd5, 11'h123,   1'b0}, exp: '{3'd5, 11'h123,   1'b0}};
    vecs[3] = '{req: '{3'd0, 11'd1,     1'b1}, exp: '{3'd0, 11'd1,     1'b1}};
    do_reset();
    chk("reset_outputs", all_out(), 64'd0);

    // request at T: reset pulse T+2..T+17, response at T+19
    for (int i = 0; i < 4; i++) begin
      push(vecs[i].req.pf, vecs[i].req.vf, vecs[i].req.vf_active);
      chk($sformatf("v%0d_pending_t1", i), bus.pending_cnt, 1);
      for (int c = 1; c <= 20; c++) begin
        if (c > 1) step();
        chk($sformatf("v%0d_rst_valid_c%0d", i, c), bus.func_rst_valid, c >= 2 && c <= 17);
        chk($sformatf("v%0d_rsp_valid_c%0d", i, c), bus.flr_rsp_valid, c == 19);
        if (c == 2)
          chk($sformatf("v%0d_rst_fields", i), {bus.func_rst_pf, bus.func_rst_vf, bus.func_rst_vf_active}, vecs[i].exp);
        if (c == 19)
          chk($sformatf("v%0d_rsp_fields", i), {bus.flr_rsp_pf, bus.flr_rsp_vf, bus.flr_rsp_vf_active}, vecs[i].exp);
      end
      chk($sformatf("v%0d_idle_outputs", i), all_out(), 64'd0);
    end

    // VF drain wait with port_idle low
    bus.port_idle = 1'b0;
    push(3'd0, 11'd5, 1'b1);
    for (int c = 0; c < 16; c++) step();
    chk("drain_last_assert", bus.func_rst_valid, 1);
    first = 0;
    for (int d = 1; d <= 100; d++) begin
      step();
      if (bus.flr_rsp_valid && first == 0) begin
        first = d;
        chk("timeout_rsp_fields", {bus.flr_rsp_pf, bus.flr_rsp_vf, bus.flr_rsp_vf_active}, {3'd0, 11'd5, 1'b1});
      end
    end
`ifdef HOST_FLR_DRAIN_TIMEOUT_EN
    chk("timeout_rsp_cycle", first, 65);
    chk("timeout_err_set", bus.timeout_err, 1);
    chk("timeout_back_idle", bus.busy, 0);
    bus.port_idle = 1'b1;
`else
    chk("drain_no_rsp", first, 0);
    chk("drain_timeout_err", bus.timeout_err, 0);
    chk("drain_rst_low", bus.func_rst_valid, 0);
    chk("drain_fields_held", {bus.func_rst_pf, bus.func_rst_vf, bus.func_rst_vf_active}, {3'd0, 11'd5, 1'b1});
    bus.port_idle = 1'b1;
    step();
    chk("drain_rsp_valid", bus.flr_rsp_valid, 1);
    chk("drain_rsp_fields", {bus.flr_rsp_pf, bus.flr_rsp_vf, bus.flr_rsp_vf_active}, {3'd0, 11'd5, 1'b1});
    step();
    chk("drain_rsp_single", bus.flr_rsp_valid, 0);
`endif

    // overflow: one request in flight, nine more pushed; the ninth is dropped
    do_reset();
    push(3'd1, 11'd100, 1'b0);
    step();
    for (int i = 0; i < 9; i++) push(3'(i), 11'(200 + i), 1'(i % 2));
    chk("ovf_pending_full", bus.pending_cnt, 8);
    chk("ovf_err_set", bus.overflow_err, 1);
    for (int c = 0; c < 400 && bus.busy; c++) begin
      step();
      if (bus.flr_rsp_valid) begin
        got_vf.push_back(bus.flr_rsp_vf);
        got_pf.push_back(bus.flr_rsp_pf);
      end
    end
    chk("ovf_busy_done", bus.busy, 0);
    nrsp = got_vf.size();
    chk("ovf_rsp_count", nrsp, 9);
    if (nrsp == 9) begin
      chk("ovf_rsp0", {got_pf[0], got_vf[0]}, {3'd1, 11'd100});
      for (int i = 0; i < 8; i++)
        chk($sformatf("ovf_rsp%0d", i + 1), {got_pf[i + 1], got_vf[i + 1]}, {3'(i), 11'(200 + i)});
    end
    chk("ovf_err_sticky", bus.overflow_err, 1);

    // push into a full queue on its pop cycle
    do_reset();
    push(3'd3, 11'd300, 1'b0);
    step();
    for (int i = 0; i < 8; i++) push(3'd4, 11'(400 + i), 1'b1);
    chk("fp_pending_full", bus.pending_cnt, 8);
    chk("fp_ovf_clear", bus.overflow_err, 0);
    first = 0;
    for (int c = 0; c < 50 && !bus.flr_rsp_valid; c++) step();
    chk("fp_rsp_seen", bus.flr_rsp_valid, 1);
    step();
    chk("fp_idle_pending", bus.pending_cnt, 8);
    chk("fp_idle_rst", bus.func_rst_valid, 0);
    push(3'd6, 11'd500, 1'b0);
    chk("fp_pending_same", bus.pending_cnt, 8);
    chk("fp_ovf_still_clear", bus.overflow_err, 0);
    chk("fp_next_rst", bus.func_rst_valid, 1);
    chk("fp_next_vf", bus.func_rst_vf, 400);
    push(3'd6, 11'd501, 1'b0);
    chk("fp_drop_ovf", bus.overflow_err, 1);
    chk("fp_drop_pending", bus.pending_cnt, 8);
    reset = 1'b1;
    step();
    reset = 1'b0;
    chk("fp_reset_clears", all_out(), 64'd0);

    // reset mid-ASSERT with three queued
    push(3'd2, 11'd600, 1'b0);
    push(3'd2, 11'd601, 1'b0);
    push(3'd2, 11'd602, 1'b0);
    push(3'd2, 11'd603, 1'b0);
    chk("rm_pending3", bus.pending_cnt, 3);
    chk("rm_in_assert", bus.func_rst_valid, 1);
    reset = 1'b1;
    step();
    chk("rm_outputs_zero", all_out(), 64'd0);
    reset = 1'b0;
    nrsp = 0;
    for (int c = 0; c < 60; c++) begin
      step();
      if (bus.flr_rsp_valid || bus.func_rst_valid) nrsp++;
    end
    chk("rm_no_activity", nrsp, 0);
    chk("rm_idle_outputs", all_out(), 64'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
